// File: rtl/snd_pkg.sv
// Shared sound-path definitions: audio/partial widths, the default coefficient
// format, and a reusable round-half-up + saturate helper for output stages.
package snd_pkg;

    localparam int AUDIO_W   = 16;
    localparam int PARTIAL_W = 37;
    localparam int COEF_FRAC = 16;
    localparam int NBLK_DEF  = 8;

    // Result of a round/saturate step: the audio sample plus a clip flag.
    typedef struct packed {
        logic                         clipped;
        logic signed [AUDIO_W-1:0]    val;
    } sat_res_t;

    // Round-half-up (ties toward +inf), arithmetic shift by frac (>=1), and
    // clip to AUDIO_W signed. The sum is taken as a 64-bit signed value so that
    // any narrower accumulator can be sign-extended into it.
    function automatic sat_res_t sat_round(input logic signed [63:0] sum,
                                           input int unsigned        frac);
        logic signed [64:0] one_v;
        logic signed [64:0] max_v;
        logic signed [64:0] min_v;
        logic signed [64:0] biased;
        logic signed [64:0] shifted;
        sat_res_t           res;
        one_v   = {{64{1'b0}}, 1'b1};
        max_v   = (one_v <<< (AUDIO_W - 1)) - one_v;
        min_v   = ~max_v;
        biased  = {sum[63], sum} + (one_v <<< (frac - 1));
        shifted = biased >>> frac;
        if (shifted > max_v) begin
            res.val     = max_v[AUDIO_W-1:0];
            res.clipped = 1'b1;
        end else if (shifted < min_v) begin
            res.val     = min_v[AUDIO_W-1:0];
            res.clipped = 1'b1;
        end else begin
            res.val     = shifted[AUDIO_W-1:0];
            res.clipped = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/snd_round_sat.sv
// Combinational output conditioning: add half an output LSB, arithmetic-shift
// by FRAC, and saturate to OUT_W signed. Flags when the sample was clipped.
module snd_round_sat
    import snd_pkg::*;
#(
    parameter int ACC_W = 40,
    parameter int FRAC  = COEF_FRAC,
    parameter int OUT_W = AUDIO_W
) (
    input  logic signed [ACC_W-1:0] sum,
    output logic signed [OUT_W-1:0] sample,
    output logic                    clipped
);

    // One extra bit of headroom so the rounding bias can never wrap the sum.
    localparam logic signed [ACC_W:0] ONE   = {{ACC_W{1'b0}}, 1'b1};
    localparam logic signed [ACC_W:0] HALF  = ONE <<< (FRAC - 1);
    localparam logic signed [ACC_W:0] MAX_V = (ONE <<< (OUT_W - 1)) - ONE;
    localparam logic signed [ACC_W:0] MIN_V = ~MAX_V;

    logic signed [ACC_W:0] biased;
    logic signed [ACC_W:0] shifted;

    // Round half up, shift down to the output scale, then clamp to the rails.
    always_comb begin
        biased  = {sum[ACC_W-1], sum} + HALF;
        shifted = biased >>> FRAC;
        sample  = shifted[OUT_W-1:0];
        clipped = 1'b0;
        if (shifted > MAX_V) begin
            sample  = MAX_V[OUT_W-1:0];
            clipped = 1'b1;
        end else if (shifted < MIN_V) begin
            sample  = MIN_V[OUT_W-1:0];
            clipped = 1'b1;
        end
    end

endmodule

// File: rtl/fir_partial_accum.sv
// Accumulates NBLK consecutive 8-tap MAC partials into one FIR output sample,
// then rounds, scales by the coefficient fraction and saturates to audio width.
//
// Handshake: pinval is a one-cycle qualifier for pin with no backpressure
// (there is no ready); every qualified partial is consumed on the edge it is
// presented. doutval is a one-cycle pulse qualifying dout/sat; the consumer
// must accept it on that cycle. clr wins over pinval in the same cycle.
module fir_partial_accum
    import snd_pkg::*;
#(
    parameter int NBLK      = NBLK_DEF,
    parameter int IN_W      = PARTIAL_W,
    parameter int ACC_W     = 40,
    parameter int COEF_FRAC = snd_pkg::COEF_FRAC,
    parameter int OUT_W     = AUDIO_W
) (
    input  logic                        ACLK,
    input  logic                        ARST,
    input  logic                        clr,
    input  logic signed [IN_W-1:0]      pin,
    input  logic                        pinval,
    output logic [$clog2(NBLK)-1:0]     blk_idx,
    output logic signed [OUT_W-1:0]     dout,
    output logic                        doutval,
    output logic                        sat,
    output logic                        sat_stk
);

    localparam int CNT_W = $clog2(NBLK);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBLK - 1);

    logic [CNT_W-1:0]        cnt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum_reg;
    logic                    fin;

    logic signed [ACC_W-1:0] pin_ext;
    logic signed [ACC_W-1:0] acc_next;
    logic                    last_blk;
    logic signed [OUT_W-1:0] rs_sample;
    logic                    rs_clipped;

    // Partial 0 restarts the sum; later partials add onto it. Because NBLK>=2
    // the final partial never coincides with cnt==0, so acc_next is the full sum.
    always_comb begin
        pin_ext  = {{(ACC_W - IN_W){pin[IN_W-1]}}, pin};
        acc_next = (cnt == '0) ? pin_ext : acc + pin_ext;
        last_blk = (cnt == LAST_IDX);
    end

    // The counter is the block position; it is exported directly to the feeder.
    assign blk_idx = cnt;

    // Stage A: accumulate qualified partials and hand the finished sum to stage B.
    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            cnt     <= '0;
            acc     <= '0;
            sum_reg <= '0;
            fin     <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            fin <= 1'b0;
        end else if (pinval) begin
            acc <= acc_next;
            cnt <= last_blk ? '0 : cnt + CNT_W'(1);
            fin <= last_blk;
            if (last_blk) begin
                sum_reg <= acc_next;
            end
        end else begin
            fin <= 1'b0;
        end
    end

    snd_round_sat #(
        .ACC_W (ACC_W),
        .FRAC  (COEF_FRAC),
        .OUT_W (OUT_W)
    ) u_round_sat (
        .sum     (sum_reg),
        .sample  (rs_sample),
        .clipped (rs_clipped)
    );

    // Stage B: register the conditioned sample; clr drops a sample still pending in fin.
    always_ff @(posedge ACLK or posedge ARST) begin
        if (ARST) begin
            dout    <= '0;
            doutval <= 1'b0;
            sat     <= 1'b0;
            sat_stk <= 1'b0;
        end else if (clr) begin
            doutval <= 1'b0;
            sat     <= 1'b0;
            sat_stk <= 1'b0;
        end else if (fin) begin
            dout    <= rs_sample;
            doutval <= 1'b1;
            sat     <= rs_clipped;
            sat_stk <= sat_stk | rs_clipped;
        end else begin
            doutval <= 1'b0;
            sat     <= 1'b0;
        end
    end

endmodule
